// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM encoding and slice width for the sequential adder
package adder_pkg;
  localparam int SLICE_W = 8;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/full_adder8.sv
// full_adder8: 8-bit ripple-carry adder used as the shared slice datapath
module full_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [8:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[8];
endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: WIDTH-bit add sequenced byte-by-byte through one full_adder8
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             busy
);
  localparam int N_SLICE = WIDTH / SLICE_W;
  localparam int CNT_W = N_SLICE > 1 ? $clog2(N_SLICE) : 1;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic c_q, s_co, last;
  logic [7:0] s_sum;
  logic [WIDTH+7:0] sum_cat;
  full_adder8 u_fa (
    .a (a_q[7:0]),
    .b (b_q[7:0]),
    .ci(c_q),
    .s (s_sum),
    .co(s_co)
  );
  // new slice enters at the top so the LS slice lands at bit 0 after N_SLICE shifts
  always_comb begin
    last      = cnt == CNT_W'(N_SLICE - 1);
    sum_cat   = {s_sum, sum_q};
    in_ready  = state == ST_IDLE;
    out_valid = state == ST_DONE;
    busy      = state != ST_IDLE;
    out_sum   = sum_q;
    out_co    = c_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      c_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          state <= ST_RUN;
          a_q   <= in_a;
          b_q   <= in_b;
          c_q   <= in_ci;
          cnt   <= '0;
        end
        ST_RUN: begin
          sum_q <= sum_cat[WIDTH+7:8];
          a_q   <= a_q >> SLICE_W;
          b_q   <= b_q >> SLICE_W;
          c_q   <= s_co;
          cnt   <= last ? cnt : cnt + 1'b1;
          state <= last ? ST_DONE : ST_RUN;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed and random checks of the sequential adder at WIDTH 32 and 8
module tb_adder_seq_ctrl;
  localparam int NS = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 0, in_ci = 0;
  logic [31:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_co, busy;
  logic [31:0] out_sum;
  logic v8 = 0, r8 = 0, ci8 = 0;
  logic [7:0] a8 = '0, b8 = '0;
  logic rdy8, ov8, co8, busy8;
  logic [7:0] s8;
  int vectors = 0, errs = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co), .busy(busy)
  );
  adder_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
    .in_a(a8), .in_b(b8), .in_ci(ci8), .out_valid(ov8),
    .out_ready(r8), .out_sum(s8), .out_co(co8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // accept one request and wait for its result; result left pending
  task automatic start32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] exp;
    int n;
    exp = {1'b0, a} + {1'b0, b} + 33'(ci);
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1; in_a = a; in_b = b; in_ci = ci;
    @(negedge clk);
    in_valid = 0; in_a = $urandom; in_b = $urandom; in_ci = 1'($urandom);
    chk({tag, " busy"}, busy, 1);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, NS);
    chk({tag, " sum"}, out_sum, exp[31:0]);
    chk({tag, " co"}, out_co, exp[32]);
  endtask

  task automatic finish32(input string tag);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, " out_valid_drop"}, out_valid, 0);
    chk({tag, " in_ready_back"}, in_ready, 1);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] exp;
    int n;
    exp = {1'b0, a} + {1'b0, b} + 9'(ci);
    @(negedge clk);
    v8 = 1; a8 = a; b8 = b; ci8 = ci;
    @(negedge clk);
    v8 = 0; a8 = 8'($urandom);
    n = 0;
    while (ov8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, 1);
    chk({tag, " sum"}, s8, exp[7:0]);
    chk({tag, " co"}, co8, exp[8]);
    r8 = 1;
    @(negedge clk);
    r8 = 0;
    chk({tag, " out_valid_drop"}, ov8, 0);
  endtask

  initial begin
    logic [31:0] hs, ha, hb;
    logic hc;
    int k;
    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst out_sum", out_sum, 0);
    chk("rst out_co", out_co, 0);
    chk("rst8 in_ready", rdy8, 1);
    rst_n = 1;

    start32("t1", 32'h0000_00FF, 32'h0000_0001, 0);
    finish32("t1");
    start32("t2", 32'hFFFF_FFFF, 32'h0, 1);
    finish32("t2");

    start32("t3", 32'hDEAD_BEEF, 32'h0123_4567, 1);
    hs = out_sum; hc = out_co;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_a = $urandom; in_b = $urandom; in_ci = 1'($urandom);
      @(negedge clk);
      chk("t3 hold valid", out_valid, 1);
      chk("t3 hold sum", out_sum, hs);
      chk("t3 hold co", out_co, hc);
      chk("t3 hold in_ready", in_ready, 0);
    end
    in_valid = 0;
    finish32("t3");
    @(negedge clk);
    chk("t3 no stray accept", busy, 0);

    @(negedge clk);
    in_valid = 1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_ci = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t4 out_valid", out_valid, 0);
    chk("t4 in_ready", in_ready, 1);
    chk("t4 busy", busy, 0);
    repeat (8) @(negedge clk);
    chk("t4 no result", out_valid, 0);
    start32("t4", 32'h1234_5678, 32'h1111_1111, 0);
    chk("t4 exact sum", out_sum, 32'h2345_6789);
    finish32("t4");

    @(negedge clk);
    in_valid = 1; in_a = 1; in_b = 2; in_ci = 0; out_ready = 1;
    @(negedge clk);
    in_a = 3; in_b = 4;
    k = 0;
    while (out_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5 first lat", k, NS);
    chk("t5 first sum", out_sum, 3);
    @(negedge clk);
    chk("t5 idle after hs", in_ready, 1);
    @(negedge clk);
    chk("t5 second accept", busy, 1);
    k = 0;
    while (out_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5 second lat", k, NS);
    chk("t5 second sum", out_sum, 7);
    in_valid = 0;
    @(negedge clk);
    out_ready = 0;
    chk("t5 drain", out_valid, 0);

    for (int i = 0; i < 20; i++) begin
      ha = $urandom; hb = $urandom; hc = 1'($urandom);
      start32("rnd", ha, hb, hc);
      hs = out_sum;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd stall", out_sum, hs);
      end
      finish32("rnd");
    end

    op8("t6", 8'h80, 8'h80, 0);
    op8("t6b", 8'hFF, 8'h00, 1);
    for (int i = 0; i < 10; i++) op8("rnd8", 8'($urandom), 8'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
